// File: rtl/multimode_ff_bank_if.sv
// Control, data and status bundle for the multimode flip-flop bank.
// The master drives the bank inputs; the slave is the register bank.
interface multimode_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] sr_err;
  logic [CNT_W-1:0] act_cnt;

  modport master (
    output en, mode, a, b, clr_err,
    input  q, qbar, changed, sr_err, act_cnt
  );

  modport slave (
    input  en, mode, a, b, clr_err,
    output q, qbar, changed, sr_err, act_cnt
  );
endinterface

// File: rtl/multimode_ff_bank.sv
// Bank of JK/SR/D/T flip-flops with enable, change flags,
// sticky SR-illegal flags and a saturating activity counter.
module multimode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input logic                clk,
  input logic                reset,
  multimode_ff_bank_if.slave bus
);

  typedef enum logic [1:0] {
    M_JK = 2'b00,
    M_SR = 2'b01,
    M_D  = 2'b10,
    M_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] r_err;
  logic [CNT_W-1:0] r_cnt;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q_n;
  logic [WIDTH-1:0] w_ill;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_err_set;

  assign w_mode = mode_e'(bus.mode);

  always_comb begin
    w_q_n = r_q;
    w_ill = '0;
    unique case (w_mode)
      M_JK: begin
        for (int i = 0; i < WIDTH; i++) begin
          unique case ({bus.a[i], bus.b[i]})
            2'b00: w_q_n[i] = r_q[i];
            2'b01: w_q_n[i] = 1'b0;
            2'b10: w_q_n[i] = 1'b1;
            2'b11: w_q_n[i] = ~r_q[i];
          endcase
        end
      end
      M_SR: begin
        for (int i = 0; i < WIDTH; i++) begin
          unique case ({bus.a[i], bus.b[i]})
            2'b00: w_q_n[i] = r_q[i];
            2'b01: w_q_n[i] = 1'b0;
            2'b10: w_q_n[i] = 1'b1;
            2'b11: begin
              w_q_n[i] = r_q[i];
              w_ill[i] = 1'b1;
            end
          endcase
        end
      end
      M_D:  w_q_n = bus.a;
      M_T:  w_q_n = r_q ^ bus.a;
    endcase
  end

  assign w_diff    = w_q_n ^ r_q;
  assign w_err_set = bus.en ? w_ill : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= RESET_VAL;
      r_chg <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      if (bus.en) begin
        r_q   <= w_q_n;
        r_chg <= w_diff;
        if (|w_diff && r_cnt != CNT_MAX)
          r_cnt <= r_cnt + 1'b1;
      end else begin
        r_chg <= '0;
      end
      // a fresh illegal input wins over a same-edge clear
      if (bus.clr_err)
        r_err <= w_err_set;
      else
        r_err <= r_err | w_err_set;
    end
  end

  assign bus.q       = r_q;
  assign bus.qbar    = ~r_q;
  assign bus.changed = r_chg;
  assign bus.sr_err  = r_err;
  assign bus.act_cnt = r_cnt;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Scoreboard bench: random and directed stimulus against a
// behavioural model, two counter widths driven in lockstep.
module tb_multimode_ff_bank;

  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'b1010;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multimode_ff_bank_if #(.WIDTH(W), .CNT_W(8)) bus8 ();
  multimode_ff_bank_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

  multimode_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  multimode_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic [W-1:0] chg;
    logic [W-1:0] err;
    int           c8;
    int           c2;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] mq;
  logic [W-1:0] merr;
  int           mc8;
  int           mc2;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t",
                  nm, act, req, $time);
  endtask

  // Model works bit by bit straight from the truth tables.
  task automatic step(input bit rst, input bit en, input int md,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit clr);
    exp_t e;
    logic [W-1:0] nq;
    logic [W-1:0] ill;
    @(negedge clk);
    reset = rst;
    bus8.en = en;      bus2.en = en;
    bus8.mode = 2'(md); bus2.mode = 2'(md);
    bus8.a = a;        bus2.a = a;
    bus8.b = b;        bus2.b = b;
    bus8.clr_err = clr; bus2.clr_err = clr;
    nq = mq;
    ill = '0;
    for (int i = 0; i < W; i++) begin
      if (md == 2) nq[i] = a[i];
      else if (md == 3) nq[i] = mq[i] ^ a[i];
      else if (a[i] && b[i]) begin
        if (md == 0) nq[i] = !mq[i];
        else ill[i] = 1'b1;
      end
      else if (a[i]) nq[i] = 1'b1;
      else if (b[i]) nq[i] = 1'b0;
    end
    if (rst) begin
      mq = RV; merr = '0; mc8 = 0; mc2 = 0;
      e.chg = '0;
    end else begin
      if (!en) ill = '0;
      merr = clr ? ill : (merr | ill);
      if (en) begin
        e.chg = nq ^ mq;
        if (nq != mq) begin
          if (mc8 < 255) mc8++;
          if (mc2 < 3) mc2++;
        end
        mq = nq;
      end else begin
        e.chg = '0;
      end
    end
    e.q = mq;
    e.qbar = ~mq;
    e.err = merr;
    e.c8 = mc8;
    e.c2 = mc2;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q",       int'(bus8.q),       int'(e.q));
      chk("qbar",    int'(bus8.qbar),    int'(e.qbar));
      chk("changed", int'(bus8.changed), int'(e.chg));
      chk("sr_err",  int'(bus8.sr_err),  int'(e.err));
      chk("act_cnt", int'(bus8.act_cnt), e.c8);
      chk("q_w2",    int'(bus2.q),       int'(e.q));
      chk("act_cnt_w2", int'(bus2.act_cnt), e.c2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    mq = RV; merr = '0; mc8 = 0; mc2 = 0;
    reset = 1'b1;
    bus8.en = 1'b0; bus2.en = 1'b0;
    bus8.mode = '0; bus2.mode = '0;
    bus8.a = '0; bus2.a = '0;
    bus8.b = '0; bus2.b = '0;
    bus8.clr_err = 1'b0; bus2.clr_err = 1'b0;

    step(1, 1, 2, 4'hF, 4'h0, 0);
    step(0, 1, 2, 4'h0, 4'h0, 0);
    step(0, 1, 0, 4'b0000, 4'b1111, 0);
    step(0, 1, 0, 4'b1111, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 4'b0000, 0);
    step(0, 1, 0, 4'b1111, 4'b1111, 0);
    step(0, 1, 0, 4'b1111, 4'b1111, 0);

    step(0, 1, 2, 4'b0000, 4'b0000, 0);
    step(0, 1, 1, 4'b0011, 4'b0101, 0);
    step(0, 1, 1, 4'b0100, 4'b0100, 1);

    step(0, 1, 2, 4'b1001, W'($urandom), 0);
    step(0, 1, 3, 4'b0011, W'($urandom), 0);
    step(0, 1, 3, 4'b0011, W'($urandom), 0);

    for (int i = 0; i < 5; i++)
      step(0, 0, $urandom_range(0, 3), W'($urandom), W'($urandom), 0);
    step(0, 0, 1, 4'h0, 4'h0, 1);

    for (int i = 0; i < 6; i++)
      step(0, 1, 3, 4'b0001, W'($urandom), 0);

    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 4'b1111, 4'b1111, 0);
    step(1, 1, 0, 4'b1111, 4'b1111, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 4'b1111, 4'b1111, 0);

    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           $urandom_range(0, 3), ra, rb, ($urandom_range(0, 7) == 0));
    end

    @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multimode_ff_bank.md
Name: multimode_ff_bank

Overview:
- Parametrised bank of WIDTH edge-triggered storage bits.
- Each bit behaves as a JK, SR, D or T flip-flop, chosen by a run-time mode select that applies to the whole bank.
- Extends the single JK bit into a multi-bit register with:
  - clock enable
  - per-bit change flags
  - sticky detection of illegal SR input
  - a saturating activity counter
- Used as the general-purpose flip-flop primitive for later counter and register exercises in the codebase.

Parameters:
- WIDTH, 8, number of storage bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 8, width of the activity counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; highest priority.
- en  input  1  clock enable; 0 = hold all state except reset and clr_err effects.
- mode  input  2  bank-wide select: 00 JK, 01 SR, 10 D, 11 T.
- a  input  WIDTH  per-bit primary input. Meaning by mode: J (JK), S (SR), D (D), T (T).
- b  input  WIDTH  per-bit secondary input. Meaning by mode: K (JK), R (SR); ignored in D and T modes.
- clr_err  input  1  synchronous clear of sr_err.
- q  output  WIDTH  stored value.
- qbar  output  WIDTH  bitwise complement of q, always.
- changed  output  WIDTH  registered per-bit flag: bit i = 1 iff q[i] changed on the previous edge.
- sr_err  output  WIDTH  sticky per-bit flag: illegal S=R=1 seen while in SR mode.
- act_cnt  output  CNT_W  count of edges on which any q bit changed; saturating.

Behaviour:
- Reset (reset=1 at a rising edge) overrides en, mode, clr_err and all inputs:
  - q=RESET_VAL, qbar=~RESET_VAL
  - changed=0, sr_err=0, act_cnt=0
- Reset asserted mid-operation takes effect at the next edge; no partial update of any output.
- en=0, reset=0:
  - q and act_cnt hold.
  - changed=0 on the next edge.
  - clr_err still acts.
- en=1: per-bit next state q_n, computed from the current q:
  - JK: a=0,b=0 hold; a=0,b=1 clear; a=1,b=0 set; a=1,b=1 toggle.
  - SR: a=0,b=0 hold; a=0,b=1 clear; a=1,b=0 set; a=1,b=1 illegal → bit holds and sr_err[i] sets.
  - D: q_n=a; b ignored.
  - T: q_n = q ^ a; b ignored.
- Latency: q reflects the inputs one edge after sampling; there is no combinational path from inputs to q.
- qbar is exactly ~q at all times, including reset. It is derived from q, not separately stored.
- changed = q_n ^ q, registered on the same edge as the q update; valid in the cycle following that update.
- sr_err:
  - Set only in SR mode with en=1.
  - Bits clear only on reset or clr_err=1.
  - If clr_err=1 and a new illegal condition occur on the same edge, set wins for the offending bit; other bits clear.
- act_cnt:
  - Increments by 1 on each en=1 edge where (q_n ^ q) != 0.
  - Saturates at 2^CNT_W−1; no wrap.
- Mode change: takes effect on the edge at which the new mode is sampled; no pipeline flush or state reset.
- No X propagation from b in D or T mode.

Test Plan:
- WIDTH=4, RESET_VAL=4'b1010. Assert reset for 1 edge with en=1, a=4'hF, mode=D → q=1010, qbar=0101, changed=0, sr_err=0, act_cnt=0.
- JK mode, en=1, edge-by-edge stimulus and required q after each edge, starting from q=0000:
  - a=0000 b=1111 → q=0000.
  - a=1111 b=0000 → q=1111, changed=1111 the next cycle.
  - a=0 b=0 → q=1111, changed=0000.
  - a=1111 b=1111 → q=0000.
  - a=1111 b=1111 → q=1111.
  - After these five edges, act_cnt=3.
- SR mode, q=0000:
  - a=0011 b=0101 → q=0010 (bit0 held), sr_err=0001.
  - Next edge: clr_err=1 with a=0100 b=0100 → sr_err=0100 (set wins on bit2, bit0 cleared), q=0010.
- D and T mode:
  - D, a=1001, b=X → q=1001.
  - Switch to T, a=0011 → q=1010.
  - Same T input again → q=1001.
- Enable and saturation:
  - en=0 with toggling inputs for 5 edges → q, act_cnt unchanged, changed=0.
  - With CNT_W=2, T mode a=0001 for 6 edges → act_cnt stops at 3.
- Reset mid-sequence: during JK toggling, assert reset for one edge → next cycle q=RESET_VAL, act_cnt=0. Toggling resumes on the following edge.
